multi_slot_predictor: RTL and testbench

Parametrised fetch-stage direction predictor for a SLOTS-wide aligned fetch group. It sits between the BTB lookup (per-slot hit and target) and the PC mux, and produces the next fetch PC in the same cycle. It keeps per-slot local history, with separate speculative and committed copies, plus 2^CNT_WIDTH-state saturating counters. It trains from the execute stage and repairs speculative history on a mispredict.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/local_hist_table.sv | 76 +++++++
 rtl/multi_slot_predictor.sv | 95 +++++++++
 tb/tb_multi_slot_predictor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for the multi-slot direction predictor: counter reset value,
// saturating counter update and PC field extraction.
package bp_pkg;

    localparam int CNT_WIDTH_DEF = 2;
    localparam int CNT_INIT      = (1 << (CNT_WIDTH_DEF - 1)) - 1;

    // Weakly not-taken value for a counter of the given width.
    function automatic int cnt_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int sat_upd(input int cnt, input logic up, input int cnt_w);
        int max_v;
        max_v = (1 << cnt_w) - 1;
        if (up)
            return (cnt == max_v) ? cnt : cnt + 1;
        else
            return (cnt == 0) ? cnt : cnt - 1;
    endfunction

    function automatic int pc_idx(input logic [63:0] pc, input int idx_depth, input int sb);
        return int'((pc >> (sb + 2)) & ((64'd1 << idx_depth) - 64'd1));
    endfunction

    function automatic int pc_slot(input logic [63:0] pc, input int sb);
        return int'((pc >> 2) & ((64'd1 << sb) - 64'd1));
    endfunction

endpackage

// File: rtl/local_hist_table.sv
// Per-slot local history table: speculative and committed histories, trained
// bits and one saturating counter per (entry, history value).
module local_hist_table
    import bp_pkg::*;
#(
    parameter int IDX_DEPTH  = 5,
    parameter int HIST_WIDTH = 2,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [IDX_DEPTH-1:0] rd_idx,
    output logic                 rd_trained,
    output logic                 rd_pred,
    input  logic                 spec_we,
    input  logic                 spec_bit,
    input  logic                 tr_we,
    input  logic [IDX_DEPTH-1:0] tr_idx,
    input  logic                 tr_taken,
    input  logic                 repair
);
    localparam int ENTRIES = 1 << IDX_DEPTH;
    localparam int HSTATES = 1 << HIST_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(cnt_init(CNT_WIDTH));

    logic [HIST_WIDTH-1:0] spec_hist_q [ENTRIES];
    logic [HIST_WIDTH-1:0] spec_hist_d [ENTRIES];
    logic [HIST_WIDTH-1:0] com_hist_q  [ENTRIES];
    logic [HIST_WIDTH-1:0] com_hist_d  [ENTRIES];
    logic [CNT_WIDTH-1:0]  ctr_q [ENTRIES][HSTATES];
    logic [CNT_WIDTH-1:0]  ctr_d [ENTRIES][HSTATES];
    logic [ENTRIES-1:0]    trained_q, trained_d;
    logic [HIST_WIDTH-1:0] rd_hist, tr_hist;

    assign rd_hist    = spec_hist_q[rd_idx];
    assign tr_hist    = com_hist_q[tr_idx];
    assign rd_trained = trained_q[rd_idx];
    assign rd_pred    = ctr_q[rd_idx][rd_hist][CNT_WIDTH-1];

    always_comb begin
        spec_hist_d = spec_hist_q;
        com_hist_d  = com_hist_q;
        ctr_d       = ctr_q;
        trained_d   = trained_q;
        if (tr_we) begin
            ctr_d[tr_idx][tr_hist] =
                CNT_WIDTH'(sat_upd(int'(ctr_q[tr_idx][tr_hist]), tr_taken, CNT_WIDTH));
            com_hist_d[tr_idx] = HIST_WIDTH'({tr_hist, tr_taken});
            trained_d[tr_idx]  = 1'b1;
        end
        // Repair restores from the committed copy including this cycle's training,
        // and overrides the fetch-side speculative shift.
        if (repair)
            spec_hist_d = com_hist_d;
        else if (spec_we)
            spec_hist_d[rd_idx] = HIST_WIDTH'({rd_hist, spec_bit});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trained_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                spec_hist_q[i] <= '0;
                com_hist_q[i]  <= '0;
                for (int h = 0; h < HSTATES; h++)
                    ctr_q[i][h] <= CNT_RST;
            end
        end else begin
            spec_hist_q <= spec_hist_d;
            com_hist_q  <= com_hist_d;
            ctr_q       <= ctr_d;
            trained_q   <= trained_d;
        end
    end

endmodule

// File: rtl/multi_slot_predictor.sv
// Fetch-stage direction predictor for an aligned SLOTS-wide fetch group:
// per-slot local-history tables, first-taken priority select and next-PC mux.
module multi_slot_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SLOTS      = 2,
    parameter int IDX_DEPTH  = 5,
    parameter int HIST_WIDTH = 2,
    parameter int CNT_WIDTH  = 2,
    localparam int SB        = $clog2(SLOTS)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic [ADDR_WIDTH-1:0]       pc_now,
    input  logic [SLOTS-1:0]            exist,
    input  logic [SLOTS*ADDR_WIDTH-1:0] target,
    input  logic                        ex_vld,
    input  logic [ADDR_WIDTH-1:0]       ex_pc,
    input  logic                        ex_taken,
    input  logic                        ex_wrong,
    output logic [ADDR_WIDTH-1:0]       pc_new,
    output logic                        branch,
    output logic [SB-1:0]               slot,
    output logic                        known
);
    localparam int GW = ADDR_WIDTH - SB - 2;

    logic [IDX_DEPTH-1:0]  idx_now, idx_ex;
    logic [SB-1:0]         slot_now, slot_ex;
    logic [SLOTS-1:0]      active, trained, pred, dir, spec_we;
    logic [ADDR_WIDTH-1:0] tgt [SLOTS];
    logic                  repair, taken_seen;

    assign idx_now  = IDX_DEPTH'(pc_idx(64'(pc_now), IDX_DEPTH, SB));
    assign idx_ex   = IDX_DEPTH'(pc_idx(64'(ex_pc), IDX_DEPTH, SB));
    assign slot_now = SB'(pc_slot(64'(pc_now), SB));
    assign slot_ex  = SB'(pc_slot(64'(ex_pc), SB));
    assign repair   = ex_vld & ex_wrong;
    assign known    = |active;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        assign tgt[s]    = target[s*ADDR_WIDTH +: ADDR_WIDTH];
        assign active[s] = exist[s] && (s >= int'(slot_now));
        // Untrained slots fall back to backward-taken / forward-not-taken.
        assign dir[s]    = active[s] &&
                           (trained[s] ? pred[s]
                                       : (tgt[s][ADDR_WIDTH-1:2] < pc_now[ADDR_WIDTH-1:2]));

        local_hist_table #(
            .IDX_DEPTH  (IDX_DEPTH),
            .HIST_WIDTH (HIST_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_tbl (
            .clk        (clk),
            .rstn       (rstn),
            .rd_idx     (idx_now),
            .rd_trained (trained[s]),
            .rd_pred    (pred[s]),
            .spec_we    (spec_we[s]),
            .spec_bit   (dir[s]),
            .tr_we      (ex_vld && (slot_ex == SB'(s))),
            .tr_idx     (idx_ex),
            .tr_taken   (ex_taken),
            .repair     (repair)
        );
    end

    always_comb begin
        branch = 1'b0;
        slot   = '0;
        pc_new = {pc_now[ADDR_WIDTH-1:SB+2] + GW'(1), (SB+2)'(0)};
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (dir[s]) begin
                branch = 1'b1;
                slot   = SB'(s);
                pc_new = {tgt[s][ADDR_WIDTH-1:2], 2'b00};
            end
        end
    end

    // Speculative history shifts only for slots up to and including the first taken one.
    always_comb begin
        spec_we    = '0;
        taken_seen = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (!taken_seen && active[s] && trained[s])
                spec_we[s] = en;
            if (dir[s])
                taken_seen = 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_slot_predictor.sv
// Self-checking bench: reset-state vector table, hand sequences for training,
// saturation, repair and async reset, then random traffic against a model.
module tb_multi_slot_predictor;
    localparam int AW = 32, SLOTS = 2, IDXD = 5, HW = 2, CW = 2, SB = 1;
    localparam int ENT = 1 << IDXD, HS = 1 << HW;

    logic clk = 1'b0;
    logic rstn, en, ex_vld, ex_taken, ex_wrong, branch, known;
    logic [AW-1:0] pc_now, ex_pc, pc_new;
    logic [SLOTS-1:0] exist;
    logic [SLOTS*AW-1:0] target;
    logic [SB-1:0] slot;

    int n_run = 0, n_fail = 0;

    int spec_m [ENT][SLOTS];
    int com_m  [ENT][SLOTS];
    int ctr_m  [ENT][SLOTS][HS];
    bit trn_m  [ENT][SLOTS];

    typedef struct {
        logic [AW-1:0]    pc;
        logic [SLOTS-1:0] ex;
        logic [AW-1:0]    t0, t1;
        bit               b;
        int               sl;
        logic [AW-1:0]    pn;
        bit               k;
    } vec_t;
    vec_t vt [9];

    multi_slot_predictor #(.ADDR_WIDTH(AW), .SLOTS(SLOTS), .IDX_DEPTH(IDXD),
                           .HIST_WIDTH(HW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .pc_now(pc_now), .exist(exist),
        .target(target), .ex_vld(ex_vld), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_wrong(ex_wrong), .pc_new(pc_new), .branch(branch), .slot(slot),
        .known(known)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++)
            for (int s = 0; s < SLOTS; s++) begin
                spec_m[i][s] = 0;
                com_m[i][s]  = 0;
                trn_m[i][s]  = 1'b0;
                for (int h = 0; h < HS; h++) ctr_m[i][s][h] = (1 << (CW - 1)) - 1;
            end
    endfunction

    function automatic void model_predict(output bit b, output int sl, output logic [AW-1:0] pn,
                                          output bit k, output bit [SLOTS-1:0] d);
        int sn, ix;
        logic [AW-1:0] t;
        sn = int'((pc_now >> 2) % SLOTS);
        ix = int'((pc_now >> (SB + 2)) % ENT);
        b = 1'b0; sl = 0; k = 1'b0; d = '0;
        pn = (pc_now & ~AW'(4 * SLOTS - 1)) + AW'(4 * SLOTS);
        for (int s = 0; s < SLOTS; s++) begin
            t = target[s*AW +: AW];
            if (s >= sn && exist[s]) begin
                k = 1'b1;
                if (trn_m[ix][s]) d[s] = ctr_m[ix][s][spec_m[ix][s]] >= (1 << (CW - 1));
                else              d[s] = (t >> 2) < (pc_now >> 2);
                if (d[s] && !b) begin
                    b = 1'b1; sl = s; pn = t & ~AW'(3);
                end
            end
        end
    endfunction

    function automatic void model_step();
        bit b, k;
        int sl, sn, ix, ei, es, h, c;
        logic [AW-1:0] pn;
        bit [SLOTS-1:0] d;
        model_predict(b, sl, pn, k, d);
        sn = int'((pc_now >> 2) % SLOTS);
        ix = int'((pc_now >> (SB + 2)) % ENT);
        if (en && !(ex_vld && ex_wrong)) begin
            for (int s = sn; s < SLOTS; s++) begin
                if (exist[s] && trn_m[ix][s]) spec_m[ix][s] = ((spec_m[ix][s] << 1) | int'(d[s])) % HS;
                if (d[s]) break;
            end
        end
        if (ex_vld) begin
            ei = int'((ex_pc >> (SB + 2)) % ENT);
            es = int'((ex_pc >> 2) % SLOTS);
            h  = com_m[ei][es];
            c  = ctr_m[ei][es][h];
            if (ex_taken) c = (c == (1 << CW) - 1) ? c : c + 1;
            else          c = (c == 0) ? 0 : c - 1;
            ctr_m[ei][es][h] = c;
            com_m[ei][es] = ((h << 1) | int'(ex_taken)) % HS;
            trn_m[ei][es] = 1'b1;
            if (ex_wrong)
                for (int i = 0; i < ENT; i++)
                    for (int s = 0; s < SLOTS; s++) spec_m[i][s] = com_m[i][s];
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic [AW-1:0] pc, input logic [SLOTS-1:0] ex,
                             input logic [AW-1:0] t0, input logic [AW-1:0] t1, input logic e);
        pc_now = pc; exist = ex; target = {t1, t0}; en = e;
    endtask

    task automatic set_ex(input logic v, input logic [AW-1:0] pc, input logic tk, input logic wr);
        ex_vld = v; ex_pc = pc; ex_taken = tk; ex_wrong = wr;
    endtask

    task automatic expect_pred(input string name, input bit b, input int sl, input logic [AW-1:0] pn);
        #1;
        check({name, ".branch"}, 64'(branch), 64'(b));
        check({name, ".slot"},   64'(slot),   64'(sl));
        check({name, ".pc_new"}, 64'(pc_new), 64'(pn));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_fetch('0, '0, '0, '0, 1'b0);
        set_ex(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #3 rstn = 1'b1;
        #1;
    endtask

    task automatic rand_check();
        bit b, k;
        int sl;
        logic [AW-1:0] pn;
        bit [SLOTS-1:0] d;
        #1;
        model_predict(b, sl, pn, k, d);
        check("rnd.branch", 64'(branch), 64'(b));
        check("rnd.slot",   64'(slot),   64'(sl));
        check("rnd.pc_new", 64'(pc_new), 64'(pn));
        check("rnd.known",  64'(known),  64'(k));
    endtask

    function automatic logic [AW-1:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 + AW'(4 * $urandom_range(0, 3));
        return 32'h1000 + AW'(4 * $urandom_range(0, 15));
    endfunction

    initial begin
        vt[0] = '{32'h1000, 2'b10, 32'h0, 32'h0F00, 1'b1, 1, 32'h0F00, 1'b1};
        vt[1] = '{32'h1000, 2'b00, 32'h0, 32'h0, 1'b0, 0, 32'h1008, 1'b0};
        vt[2] = '{32'h1000, 2'b01, 32'h2000, 32'h0, 1'b0, 0, 32'h1008, 1'b1};
        vt[3] = '{32'h1004, 2'b01, 32'h0100, 32'h0, 1'b0, 0, 32'h1008, 1'b0};
        vt[4] = '{32'h1004, 2'b11, 32'h0100, 32'h0200, 1'b1, 1, 32'h0200, 1'b1};
        vt[5] = '{32'h1000, 2'b11, 32'h0800, 32'h0900, 1'b1, 0, 32'h0800, 1'b1};
        vt[6] = '{32'hFFFF_FFF8, 2'b00, 32'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0};
        vt[7] = '{32'hFFFF_FFFC, 2'b10, 32'h0, 32'hFFFF_FFFC, 1'b0, 0, 32'h0, 1'b1};
        vt[8] = '{32'h2000, 2'b01, 32'h1003, 32'h0, 1'b1, 0, 32'h1000, 1'b1};

        do_reset();
        #1;
        check("rst.branch", 64'(branch), 64'd0);
        check("rst.pc_new", 64'(pc_new), 64'h8);
        check("rst.known",  64'(known),  64'd0);

        foreach (vt[i]) begin
            set_fetch(vt[i].pc, vt[i].ex, vt[i].t0, vt[i].t1, 1'b0);
            expect_pred($sformatf("vec%0d", i), vt[i].b, vt[i].sl, vt[i].pn);
            check($sformatf("vec%0d.known", i), 64'(known), 64'(vt[i].k));
        end

        // Training to taken, then decay to saturated not-taken.
        do_reset();
        set_fetch(32'h1000, 2'b01, 32'h2000, 32'h0, 1'b0);
        set_ex(1'b1, 32'h1000, 1'b1, 1'b0);
        repeat (3) tick();
        set_ex(1'b0, '0, 1'b0, 1'b0);
        expect_pred("train_t", 1'b1, 0, 32'h2000);
        set_ex(1'b1, 32'h1000, 1'b0, 1'b0);
        repeat (6) tick();
        set_ex(1'b0, '0, 1'b0, 1'b0);
        expect_pred("train_sat0", 1'b0, 0, 32'h1008);

        // Slot before the fetch offset is ignored even when trained taken.
        do_reset();
        set_ex(1'b1, 32'h1000, 1'b1, 1'b0);
        tick();
        set_ex(1'b0, '0, 1'b0, 1'b0);
        set_fetch(32'h1000, 2'b11, 32'h2000, 32'h0800, 1'b0);
        expect_pred("slot0_win", 1'b1, 0, 32'h2000);
        set_fetch(32'h1004, 2'b11, 32'h2000, 32'h0800, 1'b0);
        expect_pred("slot0_skip", 1'b1, 1, 32'h0800);
        check("slot0_skip.known", 64'(known), 64'd1);

        // Speculative shift, then repair that overrides the same-cycle shift.
        set_fetch(32'h1000, 2'b01, 32'h2000, 32'h0, 1'b1);
        expect_pred("spec_pre", 1'b1, 0, 32'h2000);
        tick();
        en = 1'b0;
        expect_pred("spec_shift", 1'b0, 0, 32'h1008);
        en = 1'b1;
        set_ex(1'b1, 32'h1000, 1'b1, 1'b1);
        tick();
        en = 1'b0;
        set_ex(1'b0, '0, 1'b0, 1'b0);
        expect_pred("repair", 1'b0, 0, 32'h1008);
        set_ex(1'b1, 32'h1000, 1'b1, 1'b0);
        tick();
        set_ex(1'b0, '0, 1'b0, 1'b0);
        expect_pred("repair_hist", 1'b1, 0, 32'h2000);

        // Fetch shift and training on the same entry in one cycle both land.
        do_reset();
        set_ex(1'b1, 32'h1000, 1'b1, 1'b0);
        tick();
        set_fetch(32'h1000, 2'b01, 32'h2000, 32'h0, 1'b1);
        tick();
        en = 1'b0;
        set_ex(1'b0, '0, 1'b0, 1'b0);
        expect_pred("dual_ctr", 1'b1, 0, 32'h2000);
        en = 1'b1;
        tick();
        en = 1'b0;
        expect_pred("dual_spec", 1'b0, 0, 32'h1008);

        // Async reset mid-cycle drops the pending training and clears state at once.
        do_reset();
        set_ex(1'b1, 32'h1000, 1'b1, 1'b0);
        tick();
        set_fetch(32'h1000, 2'b01, 32'h2000, 32'h0, 1'b0);
        expect_pred("ar_pre", 1'b1, 0, 32'h2000);
        rstn = 1'b0;
        model_reset();
        expect_pred("ar_async", 1'b0, 0, 32'h1008);
        @(posedge clk);
        #3;
        set_ex(1'b0, '0, 1'b0, 1'b0);
        rstn = 1'b1;
        expect_pred("ar_post", 1'b0, 0, 32'h1008);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_fetch(rand_pc(), SLOTS'($urandom_range(0, 3)),
                      32'h0F80 + AW'(4 * $urandom_range(0, 63)) + AW'($urandom_range(0, 3)),
                      32'h0F80 + AW'(4 * $urandom_range(0, 63)), 1'($urandom_range(0, 3) != 0));
            set_ex(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 5) == 0));
            rand_check();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
